vdp_mac_seq: RTL

- Sequencer for the single-cycle signed MAC (mac_nnbit_1cc) used in the vector dot-product benchmark.
- Accepts a dot-product job of up to K element pairs and joins the garbler (g) and evaluator (e) element streams.
- Drives the MAC inputs one pair per cycle, clears the accumulator between jobs, and returns the captured sum over a valid/ready result port.
- The MAC is instantiated outside this block, alongside it.

---
 rtl/vdp_mac_seq.sv | 90 +++++++++
 1 files changed

// File: rtl/vdp_mac_seq.sv
// Job sequencer for the single-cycle signed MAC: joins the g/e element streams,
// feeds one pair per cycle, clears the accumulator between jobs, returns the sum.
module vdp_mac_seq #(
    parameter int N  = 8,
    parameter int K  = 4,
    parameter int LW = $clog2(K + 1),
    parameter int OW = 2 * N + K - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    input  logic          g_valid,
    input  logic [N-1:0]  g_data,
    output logic          g_ready,
    input  logic          e_valid,
    input  logic [N-1:0]  e_data,
    output logic          e_ready,
    output logic          mac_rst,
    output logic [N-1:0]  mac_g,
    output logic [N-1:0]  mac_e,
    input  logic [OW-1:0] mac_o,
    output logic          res_valid,
    output logic [OW-1:0] res_data,
    input  logic          res_ready
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DONE} state_t;

    state_t        state, state_nx;
    logic [LW-1:0] len_q, cnt, len_clamp;
    logic          fire;

    assign len_clamp = (len > LW'(K)) ? LW'(K) : len;
    assign fire      = (state == RUN) && g_valid && e_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Job length, pair counter and the captured result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            cnt      <= '0;
            res_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                len_q <= len_clamp;
                cnt   <= '0;
            end
            if (fire)             cnt      <= cnt + LW'(1);
            if (state == CAPTURE) res_data <= mac_o;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = (len_q == '0) ? CAPTURE : RUN;
            RUN:     if (fire && cnt == len_q - LW'(1)) state_nx = CAPTURE;
            CAPTURE: state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Idle cycles feed 0*0 so a stalled pair leaves the accumulator unchanged.
    always_comb begin
        busy      = (state != IDLE);
        mac_rst   = (state == IDLE) || (state == CLEAR);
        g_ready   = 1'b0;
        e_ready   = 1'b0;
        mac_g     = '0;
        mac_e     = '0;
        res_valid = (state == DONE);
        if (state == RUN) begin
            g_ready = e_valid;
            e_ready = g_valid;
            if (fire) begin
                mac_g = g_data;
                mac_e = e_data;
            end
        end
    end

endmodule
